// File: rtl/me_scan_controller.sv
// ---- me_scan_controller : serpentine full-search motion-estimation control/address engine -- Rev 1.0 ----
`default_nettype none

module me_scan_controller #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_LAT    = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [15:0]                                sad,
  output logic                                       busy,
  output logic                                       done,
  output logic [$clog2(MACRO_DIM)-1:0]               cpr_row,
  output logic [$clog2(SEARCH_DIM)-1:0]              spr_row,
  output logic [$clog2(SEARCH_DIM)-1:0]              spr_col,
  output logic                                       en_cpr,
  output logic                                       en_spr,
  output logic [1:0]                                 sel,
  output logic                                       valid,
  output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]  mv_x,
  output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]  mv_y,
  output logic [15:0]                                best_sad
);

  localparam int NPOS   = SEARCH_DIM - MACRO_DIM + 1;
  localparam int POS_W  = $clog2(NPOS);
  localparam int ROW_W  = $clog2(SEARCH_DIM);
  localparam int CPR_W  = $clog2(MACRO_DIM);
  localparam int PIPE   = 1 + SAD_LAT;
  localparam int DCNT_W = $clog2(SAD_LAT + 2);

  localparam logic [CPR_W-1:0]  K_LAST = CPR_W'(MACRO_DIM - 1);
  localparam logic [POS_W-1:0]  V_LAST = POS_W'(NPOS - 2);
  localparam logic [POS_W-1:0]  X_LAST = POS_W'(NPOS - 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(SAD_LAT);
  localparam logic [ROW_W-1:0]  MD_ROW = ROW_W'(MACRO_DIM);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VSCAN  = 3'd2,
    S_LSHIFT = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state, nstate;
  logic [CPR_W-1:0]    k, nk;
  logic [POS_W-1:0]    vcnt, nvcnt;
  logic [DCNT_W-1:0]   dcnt, ndcnt;
  logic [POS_W-1:0]    x, nx, y, ny;
  logic                dir, ndir;        // 0 = window moving down, 1 = moving up
  logic                evt;
  logic [POS_W-1:0]    ex, ey;

  logic                n_busy, n_done, n_en_cpr, n_en_spr;
  logic [1:0]          n_sel;
  logic [CPR_W-1:0]    n_cpr_row;
  logic [ROW_W-1:0]    n_spr_row, n_spr_col;

  logic [PIPE-1:0]     vpipe;
  logic [POS_W-1:0]    xpipe [PIPE];
  logic [POS_W-1:0]    ypipe [PIPE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  // Counters describe the window currently held in the array; evt/ex/ey name
  // the candidate that this cycle's shift will place there.
  always_comb begin
    nstate = state;
    nk     = k;
    nvcnt  = vcnt;
    ndcnt  = dcnt;
    nx     = x;
    ny     = y;
    ndir   = dir;
    evt    = 1'b0;
    ex     = x;
    ey     = y;
    case (state)
      S_IDLE: begin
        if (start) begin
          nstate = S_LOAD;
          nk     = '0;
          nx     = '0;
          ny     = '0;
          ndir   = 1'b0;
        end
      end
      S_LOAD: begin
        if (k == K_LAST) begin
          nstate = S_VSCAN;
          nvcnt  = '0;
          evt    = 1'b1;
          ex     = '0;
          ey     = '0;
        end else begin
          nk = k + 1'b1;
        end
      end
      S_VSCAN: begin
        evt = 1'b1;
        ey  = dir ? (y - 1'b1) : (y + 1'b1);
        ny  = ey;
        if (vcnt == V_LAST) begin
          ndcnt  = '0;
          nstate = (x < X_LAST) ? S_LSHIFT : S_DRAIN;
        end else begin
          nvcnt = vcnt + 1'b1;
        end
      end
      S_LSHIFT: begin
        evt    = 1'b1;
        ex     = x + 1'b1;
        nx     = x + 1'b1;
        ndir   = ~dir;
        nvcnt  = '0;
        nstate = S_VSCAN;
      end
      S_DRAIN: begin
        if (dcnt == D_LAST) nstate = S_DONE;
        else                ndcnt  = dcnt + 1'b1;
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the state being entered.
  always_comb begin
    n_busy    = 1'b0;
    n_done    = 1'b0;
    n_en_cpr  = 1'b0;
    n_en_spr  = 1'b0;
    n_sel     = 2'b00;
    n_cpr_row = '0;
    n_spr_row = '0;
    n_spr_col = '0;
    case (nstate)
      S_LOAD: begin
        n_busy    = 1'b1;
        n_en_cpr  = 1'b1;
        n_en_spr  = 1'b1;
        n_sel     = 2'b01;
        n_cpr_row = nk;
        n_spr_row = ROW_W'(nk);
      end
      S_VSCAN: begin
        n_busy    = 1'b1;
        n_en_spr  = 1'b1;
        n_sel     = ndir ? 2'b00 : 2'b01;
        n_spr_row = ndir ? (ROW_W'(ny) - 1'b1) : (ROW_W'(ny) + MD_ROW);
        n_spr_col = ROW_W'(nx);
      end
      S_LSHIFT: begin
        n_busy    = 1'b1;
        n_en_spr  = 1'b1;
        n_sel     = 2'b10;
        n_spr_row = ROW_W'(ny);
        n_spr_col = ROW_W'(nx) + 1'b1;
      end
      S_DRAIN: n_busy = 1'b1;
      S_DONE:  n_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      vcnt    <= '0;
      dcnt    <= '0;
      x       <= '0;
      y       <= '0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      en_cpr  <= 1'b0;
      en_spr  <= 1'b0;
      sel     <= 2'b00;
      cpr_row <= '0;
      spr_row <= '0;
      spr_col <= '0;
      vpipe   <= '0;
      for (int i = 0; i < PIPE; i++) begin
        xpipe[i] <= '0;
        ypipe[i] <= '0;
      end
    end else begin
      k       <= nk;
      vcnt    <= nvcnt;
      dcnt    <= ndcnt;
      x       <= nx;
      y       <= ny;
      dir     <= ndir;
      busy    <= n_busy;
      done    <= n_done;
      en_cpr  <= n_en_cpr;
      en_spr  <= n_en_spr;
      sel     <= n_sel;
      cpr_row <= n_cpr_row;
      spr_row <= n_spr_row;
      spr_col <= n_spr_col;
      vpipe[0] <= evt;
      xpipe[0] <= ex;
      ypipe[0] <= ey;
      for (int i = 1; i < PIPE; i++) begin
        vpipe[i] <= vpipe[i-1];
        xpipe[i] <= xpipe[i-1];
        ypipe[i] <= ypipe[i-1];
      end
    end
  end

  assign valid = vpipe[PIPE-1];

  // Strict less-than: on a tie the earlier serpentine candidate is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad <= 16'hFFFF;
      mv_x     <= '0;
      mv_y     <= '0;
    end else if (state == S_IDLE && start) begin
      best_sad <= 16'hFFFF;
      mv_x     <= '0;
      mv_y     <= '0;
    end else if (valid && (sad < best_sad)) begin
      best_sad <= sad;
      mv_x     <= xpipe[PIPE-1];
      mv_y     <= ypipe[PIPE-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_me_scan_controller.sv
// ---- tb_me_scan_controller : randomized self-checking bench for me_scan_controller -- Rev 1.0 ----
`default_nettype none

module tb_me_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] sad;
  logic        busy, done, en_cpr, en_spr, valid;
  logic [3:0]  cpr_row;
  logic [5:0]  spr_row, spr_col, mv_x, mv_y;
  logic [1:0]  sel;
  logic [15:0] best_sad;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned tab [33][33];   // [x][y] SAD seen for each candidate

  me_scan_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sad(sad),
    .busy(busy), .done(done), .cpr_row(cpr_row), .spr_row(spr_row),
    .spr_col(spr_col), .en_cpr(en_cpr), .en_spr(en_spr), .sel(sel),
    .valid(valid), .mv_x(mv_x), .mv_y(mv_y), .best_sad(best_sad)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Serpentine visiting order: even columns top-down, odd columns bottom-up.
  function automatic void pos_of(input int idx, output int px, output int py);
    int r;
    px = idx / 33;
    r  = idx % 33;
    py = (px % 2 == 0) ? r : 32 - r;
  endfunction

  function automatic void model_best(output int bx, output int by, output int unsigned bs);
    int px, py;
    bs = 32'hFFFF; bx = 0; by = 0;
    for (int i = 0; i < 1089; i++) begin
      pos_of(i, px, py);
      if (tab[px][py] < bs) begin bs = tab[px][py]; bx = px; by = py; end
    end
  endfunction

  task automatic fill_const(input int unsigned v);
    for (int i = 0; i < 33; i++) for (int j = 0; j < 33; j++) tab[i][j] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 33; i++) for (int j = 0; j < 33; j++) tab[i][j] = $urandom_range(60000, 1000);
  endtask

  task automatic run_search(input int rst_at, input bit pulse_start,
                            output int vcnt, output int cyc, output int dcnt, output bit tmo,
                            output logic [34:0] snap, output logic [15:0] snap_best);
    int first, done_n, px, py;
    vcnt = 0; cyc = 0; dcnt = 0; tmo = 1'b0; first = -1; done_n = -1;
    snap = '1; snap_best = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 1300; n++) begin
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        snap = {busy, done, valid, en_cpr, en_spr, sel, cpr_row, spr_row, spr_col, mv_x, mv_y};
        snap_best = best_sad;
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      if (busy && first < 0) first = n;
      if (valid) begin
        if (vcnt < 1089) begin pos_of(vcnt, px, py); sad = 16'(tab[px][py]); end
        vcnt++;
      end
      start = 1'b0;
      if (pulse_start && n == 300) start = 1'b1;
      if (done) begin
        dcnt++;
        if (done_n < 0) done_n = n;
        if (pulse_start && dcnt == 1) start = 1'b1;
      end
      if (done_n >= 0 && n >= done_n + 6) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_n < 0) tmo = 1'b1;
    else            cyc = done_n - first + 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sad = 16'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, valid, en_cpr, en_spr, sel, cpr_row, spr_row, spr_col, mv_x, mv_y} !== 35'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
        {busy, done, valid, en_cpr, en_spr, sel, cpr_row, spr_row, spr_col, mv_x, mv_y});
    end
    n_checks++;
    if (best_sad !== 16'hFFFF) begin n_fail++; $display("FAIL reset_best: got %h expected ffff", best_sad); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, valid, en_spr} !== 4'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 0000", {busy, done, valid, en_spr});
    end
  endtask

  task automatic test_constant();
    int vc, cy, dc; bit tmo; logic [34:0] sn; logic [15:0] sb;
    fill_const(100);
    run_search(0, 1'b0, vc, cy, dc, tmo, sn, sb);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL const_timeout: no done within budget"); end
    n_checks++; if (vc != 1089) begin n_fail++; $display("FAIL const_valid_count: got %0d expected 1089", vc); end
    n_checks++; if (cy != 1107) begin n_fail++; $display("FAIL const_length: got %0d expected 1107", cy); end
    n_checks++; if (dc != 1) begin n_fail++; $display("FAIL const_done_count: got %0d expected 1", dc); end
    n_checks++; if ({mv_x, mv_y} !== 12'd0) begin n_fail++; $display("FAIL const_mv: got (%0d,%0d) expected (0,0)", mv_x, mv_y); end
    n_checks++; if (best_sad !== 16'd100) begin n_fail++; $display("FAIL const_best: got %0d expected 100", best_sad); end
  endtask

  task automatic test_address_trace();
    logic [21:0] got, exp;
    int m, c, j;
    sad = 16'd200;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 1107; n++) begin
      if (n <= 16) begin
        exp = {1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 4'(n - 1), 6'(n - 1), 6'd0};
      end else if (n <= 1104) begin
        m = n - 17; c = m / 33; j = m % 33;
        if (j == 32)
          exp = {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, ((c % 2 == 0) ? 6'd32 : 6'd0), 6'(c + 1)};
        else if (c % 2 == 0)
          exp = {1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 4'd0, 6'(j + 16), 6'(c)};
        else
          exp = {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 6'(31 - j), 6'(c)};
      end else if (n <= 1106) begin
        exp = {1'b1, 21'd0};
      end else begin
        exp = {1'b0, 1'b1, 20'd0};
      end
      got = {busy, done, en_cpr, en_spr, sel, cpr_row, spr_row, spr_col};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL trace cycle %0d: got busy/done/encpr/enspr/sel/cpr/row/col=%b expected %b", n, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_model(input string name);
    int vc, cy, dc, bx, by; int unsigned bs; bit tmo; logic [34:0] sn; logic [15:0] sb;
    model_best(bx, by, bs);
    run_search(0, 1'b0, vc, cy, dc, tmo, sn, sb);
    n_checks++; if (tmo || vc != 1089) begin n_fail++; $display("FAIL %s_count: valid %0d expected 1089 (timeout=%0d)", name, vc, tmo); end
    n_checks++;
    if (mv_x !== 6'(bx) || mv_y !== 6'(by) || best_sad !== 16'(bs)) begin
      n_fail++;
      $display("FAIL %s_best: got (%0d,%0d) sad %0d expected (%0d,%0d) sad %0d", name, mv_x, mv_y, best_sad, bx, by, bs);
    end
  endtask

  task automatic test_single_min();
    fill_const(500); tab[5][20] = 7;
    check_model("single_min");
    n_checks++;
    if (mv_x !== 6'd5 || mv_y !== 6'd20 || best_sad !== 16'd7) begin
      n_fail++; $display("FAIL single_min_fixed: got (%0d,%0d) %0d expected (5,20) 7", mv_x, mv_y, best_sad);
    end
  endtask

  task automatic test_tie();
    fill_const(50); tab[2][10] = 3; tab[9][4] = 3;
    check_model("tie");
    n_checks++;
    if (mv_x !== 6'd2 || mv_y !== 6'd10 || best_sad !== 16'd3) begin
      n_fail++; $display("FAIL tie_fixed: got (%0d,%0d) %0d expected (2,10) 3", mv_x, mv_y, best_sad);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      fill_random();
      check_model("random");
    end
    fill_const(16'hFFFF);
    check_model("all_ffff");
  endtask

  task automatic test_mid_reset();
    int vc, cy, dc; bit tmo, seen; logic [34:0] sn; logic [15:0] sb;
    fill_random();
    run_search(16 + 300, 1'b0, vc, cy, dc, tmo, sn, sb);
    n_checks++; if (sn !== 35'd0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected 0", sn); end
    n_checks++; if (sb !== 16'hFFFF) begin n_fail++; $display("FAIL midreset_best: got %h expected ffff", sb); end
    seen = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      if (done || busy || valid) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midreset_quiet: got activity after reset expected none"); end
    run_search(0, 1'b0, vc, cy, dc, tmo, sn, sb);
    n_checks++;
    if (tmo || cy != 1107 || vc != 1089 || dc != 1) begin
      n_fail++; $display("FAIL midreset_restart: got len %0d valid %0d done %0d expected 1107 1089 1", cy, vc, dc);
    end
  endtask

  task automatic test_start_ignored();
    int vc, cy, dc, bx, by; int unsigned bs; bit tmo; logic [34:0] sn; logic [15:0] sb;
    fill_random();
    model_best(bx, by, bs);
    run_search(0, 1'b1, vc, cy, dc, tmo, sn, sb);
    n_checks++;
    if (tmo || cy != 1107 || vc != 1089 || dc != 1) begin
      n_fail++; $display("FAIL start_ignored: got len %0d valid %0d done %0d expected 1107 1089 1", cy, vc, dc);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done: got busy %b expected 0", busy); end
    n_checks++;
    if (mv_x !== 6'(bx) || mv_y !== 6'(by) || best_sad !== 16'(bs)) begin
      n_fail++; $display("FAIL start_ignored_best: got (%0d,%0d) %0d expected (%0d,%0d) %0d", mv_x, mv_y, best_sad, bx, by, bs);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_address_trace();
    test_single_min();
    test_tie();
    test_random();
    test_mid_reset();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
